// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Holds the arbitration FSM states, the source-select tag, and the rd decoder.
package rf_write_arbiter_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    WB   = 2'd1,
    LU   = 2'd2
  } src_sel_e;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    return NUM_REGS'(1) << rd;
  endfunction

endpackage

// File: rtl/rf_result_fifo.sv
// Small FIFO of buffered long-latency results ({rd, data}).
// Exposes per-entry valid bits and rd fields so the top can build the pending mask.
module rf_result_fifo
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 push,
  input  logic [REG_ADDR_W-1:0]                push_rd,
  input  logic [XLEN-1:0]                      push_data,
  input  logic                                 pop,
  output logic [REG_ADDR_W-1:0]                head_rd,
  output logic [XLEN-1:0]                      head_data,
  output logic [CNT_W-1:0]                     count,
  output logic                                 empty,
  output logic [DEPTH-1:0]                     entry_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     entry_rd
);

  logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
  logic [XLEN-1:0]       data_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  full;
  logic                  push_ok;
  logic                  pop_ok;
  logic [DEPTH-1:0]      valid_nxt;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign head_rd   = rd_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Push and pop never target the same slot: that needs empty (no pop) or full (no push).
  always_comb begin
    valid_nxt = entry_valid;
    if (pop_ok)  valid_nxt[rd_ptr] = 1'b0;
    if (push_ok) valid_nxt[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      entry_valid <= valid_nxt;
      count       <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      rd_mem[wr_ptr]   <= push_rd;
      data_mem[wr_ptr] <= push_data;
    end
  end

  always_comb begin
    entry_rd = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_rd[i] = rd_mem[i];
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between write-back and buffered
// long-latency results; write-back wins, with a starvation-forced drain cycle.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned XLEN       = rf_write_arbiter_pkg::XLEN,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1,
  localparam int unsigned SC_W  = $clog2(STARVE_MAX) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  lu_valid,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic [XLEN-1:0]       lu_data,
  output logic                  lu_ready,
  output logic                  stall_wb,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [NUM_REGS-1:0]   pend_mask,
  output logic [CNT_W-1:0]      fifo_count
);

  arb_state_e                    state;
  src_sel_e                      sel;
  logic [SC_W-1:0]               starve_cnt;
  logic [SC_W-1:0]               starve_inc;
  logic                          fifo_push;
  logic                          fifo_pop;
  logic                          fifo_empty;
  logic [CNT_W-1:0]              count_nxt;
  logic                          wb_req;
  logic [REG_ADDR_W-1:0]         head_rd;
  logic [XLEN-1:0]               head_data;
  logic [DEPTH-1:0]              entry_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_rd;

  assign lu_ready  = (fifo_count < CNT_W'(DEPTH));
  // An x0 result is acknowledged but never stored.
  assign fifo_push = lu_valid && lu_ready && (lu_rd != '0);
  assign stall_wb  = (state == DRAIN);
  assign wb_req    = wb_valid && (wb_rd != '0) && !stall_wb;
  assign count_nxt = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
  assign starve_inc = starve_cnt + SC_W'(1);

  rf_result_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (fifo_push),
    .push_rd     (lu_rd),
    .push_data   (lu_data),
    .pop         (fifo_pop),
    .head_rd     (head_rd),
    .head_data   (head_data),
    .count       (fifo_count),
    .empty       (fifo_empty),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) pend_mask = pend_mask | rd_onehot(entry_rd[i]);
    end
  end

  always_comb begin
    sel      = NONE;
    fifo_pop = 1'b0;
    if (state == DRAIN && !fifo_empty) begin
      sel      = LU;
      fifo_pop = 1'b1;
    end else if (wb_req) begin
      sel = WB;
    end else if (!fifo_empty) begin
      sel      = LU;
      fifo_pop = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          starve_cnt <= '0;
          if (count_nxt != '0) state <= PEND;
        end
        PEND: begin
          if (count_nxt == '0) begin
            state      <= IDLE;
            starve_cnt <= '0;
          end else if (fifo_pop) begin
            starve_cnt <= '0;
          // The forced drain follows the cycle in which the wait count reaches STARVE_MAX-1.
          end else if (starve_inc == SC_W'(STARVE_MAX - 1)) begin
            state      <= DRAIN;
            starve_cnt <= '0;
          end else begin
            starve_cnt <= starve_inc;
          end
        end
        DRAIN: begin
          starve_cnt <= '0;
          state      <= (count_nxt != '0) ? PEND : IDLE;
        end
        default: begin
          state      <= IDLE;
          starve_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      case (sel)
        WB: begin
          rf_we    <= 1'b1;
          rf_rd    <= wb_rd;
          rf_wdata <= wb_data;
        end
        LU: begin
          rf_we    <= 1'b1;
          rf_rd    <= head_rd;
          rf_wdata <= head_data;
        end
        default: rf_we <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: stimulus queues expected register writes,
// a monitor pops and compares them whenever rf_we is seen.
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        stall_wb;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] pend_mask;
  logic [1:0]  fifo_count;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  rf_write_arbiter #(
    .XLEN       (32),
    .DEPTH      (2),
    .STARVE_MAX (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .lu_valid   (lu_valid),
    .lu_rd      (lu_rd),
    .lu_data    (lu_data),
    .lu_ready   (lu_ready),
    .stall_wb   (stall_wb),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_wdata   (rf_wdata),
    .pend_mask  (pend_mask),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void expect_wr(input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
  task automatic drive(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    @(posedge clk);
    #1;
    wb_valid = wv;
    wb_rd    = wrd;
    wb_data  = wd;
    lu_valid = lv;
    lu_rd    = lrd;
    lu_data  = ld;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic wb(input logic [4:0] rd);
    drive(1'b1, rd, 32'h1000 + 32'(rd), 1'b0, 5'd0, 32'h0);
  endtask

  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rf_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write", rf_rd, rf_wdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_rd", 32'(rf_rd), 32'(e.rd));
          check("wr_data", rf_wdata, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst_n    = 1'b0;
    wb_valid = 1'b0;
    wb_rd    = '0;
    wb_data  = '0;
    lu_valid = 1'b0;
    lu_rd    = '0;
    lu_data  = '0;

    // 1: reset values, then a single write-back
    repeat (2) @(negedge clk);
    check("rst_rf_we", 32'(rf_we), 0);
    check("rst_lu_ready", 32'(lu_ready), 1);
    check("rst_pend_mask", pend_mask, 0);
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_stall_wb", 32'(stall_wb), 0);
    rst_n = 1'b1;
    expect_wr(5'd5, 32'hDEADBEEF);
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    idle();
    check("t1_rf_we", 32'(rf_we), 1);

    // 2: free-slot drain
    expect_wr(5'd7, 32'h11);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h11);
    check("t2_lu_ready", 32'(lu_ready), 1);
    idle();
    check("t2_pend_mask", pend_mask, 32'h80);
    check("t2_fifo_count", 32'(fifo_count), 1);
    idle();
    check("t2_pend_clear", pend_mask, 0);
    check("t2_count_clear", 32'(fifo_count), 0);

    // 3: starvation forces one drain cycle
    expect_wr(5'd3, 32'h1003);
    expect_wr(5'd4, 32'h1004);
    expect_wr(5'd5, 32'h1005);
    expect_wr(5'd9, 32'h22);
    expect_wr(5'd6, 32'h1006);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h22);
    wb(5'd3);
    check("t3_count", 32'(fifo_count), 1);
    check("t3_pend", pend_mask, 32'h200);
    check("t3_stall_c1", 32'(stall_wb), 0);
    wb(5'd4);
    check("t3_stall_c2", 32'(stall_wb), 0);
    wb(5'd5);
    check("t3_stall_c3", 32'(stall_wb), 0);
    wb(5'd6);
    check("t3_stall_c4", 32'(stall_wb), 1);
    wb(5'd6);
    check("t3_stall_c5", 32'(stall_wb), 0);
    check("t3_drain_rd", 32'(rf_rd), 9);
    check("t3_drain_data", rf_wdata, 32'h22);
    check("t3_count_after", 32'(fifo_count), 0);
    idle();

    // 4: full FIFO under continuous write-back; drain order 10, 11, then 20
    expect_wr(5'd12, 32'h100C);
    expect_wr(5'd13, 32'h100D);
    expect_wr(5'd14, 32'h100E);
    expect_wr(5'd15, 32'h100F);
    expect_wr(5'd10, 32'hA0);
    expect_wr(5'd16, 32'h1010);
    expect_wr(5'd17, 32'h1011);
    expect_wr(5'd18, 32'h1012);
    expect_wr(5'd11, 32'hB0);
    expect_wr(5'd19, 32'h1013);
    expect_wr(5'd20, 32'hC0);
    drive(1'b1, 5'd12, 32'h100C, 1'b1, 5'd10, 32'hA0);
    check("t4_ready_c0", 32'(lu_ready), 1);
    drive(1'b1, 5'd13, 32'h100D, 1'b1, 5'd11, 32'hB0);
    check("t4_count_c1", 32'(fifo_count), 1);
    drive(1'b1, 5'd14, 32'h100E, 1'b1, 5'd20, 32'hC0);
    check("t4_ready_full", 32'(lu_ready), 0);
    check("t4_count_full", 32'(fifo_count), 2);
    check("t4_pend_full", pend_mask, 32'h0C00);
    drive(1'b1, 5'd15, 32'h100F, 1'b1, 5'd20, 32'hC0);
    check("t4_ready_c3", 32'(lu_ready), 0);
    drive(1'b1, 5'd16, 32'h1010, 1'b1, 5'd20, 32'hC0);
    check("t4_stall_c4", 32'(stall_wb), 1);
    check("t4_ready_c4", 32'(lu_ready), 0);
    drive(1'b1, 5'd16, 32'h1010, 1'b1, 5'd20, 32'hC0);
    check("t4_stall_c5", 32'(stall_wb), 0);
    check("t4_ready_c5", 32'(lu_ready), 1);
    drive(1'b1, 5'd17, 32'h1011, 1'b0, 5'd0, 32'h0);
    check("t4_count_c6", 32'(fifo_count), 2);
    check("t4_pend_c6", pend_mask, 32'h0010_0800);
    wb(5'd18);
    wb(5'd19);
    check("t4_stall_c8", 32'(stall_wb), 1);
    wb(5'd19);
    check("t4_stall_c9", 32'(stall_wb), 0);
    idle();
    idle();
    check("t4_count_end", 32'(fifo_count), 0);
    check("t4_pend_end", pend_mask, 0);

    // 5: x0 requests are acknowledged but never written or stored
    drive(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h77);
    check("t5_lu_ready", 32'(lu_ready), 1);
    idle();
    check("t5_rf_we_c1", 32'(rf_we), 0);
    check("t5_count", 32'(fifo_count), 0);
    check("t5_pend", pend_mask, 0);
    check("t5_stall", 32'(stall_wb), 0);
    idle();
    check("t5_rf_we_c2", 32'(rf_we), 0);

    // 6: asynchronous reset while an entry is pending
    expect_wr(5'd4, 32'h1004);
    drive(1'b1, 5'd4, 32'h1004, 1'b1, 5'd25, 32'h55);
    wb(5'd3);
    check("t6_count_pre", 32'(fifo_count), 1);
    check("t6_pend_pre", pend_mask, 32'h0200_0000);
    #2;
    wb_valid = 1'b0;
    lu_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("t6_count_rst", 32'(fifo_count), 0);
    check("t6_stall_rst", 32'(stall_wb), 0);
    check("t6_rf_we_rst", 32'(rf_we), 0);
    check("t6_pend_rst", pend_mask, 0);
    check("t6_ready_rst", 32'(lu_ready), 1);
    #1;
    rst_n = 1'b1;
    idle();
    idle();
    check("t6_rf_we_post", 32'(rf_we), 0);
    check("t6_count_post", 32'(fifo_count), 0);
    idle();

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the single register-file write port and shares it between two requesters.
- Requester 1: in-order write-back stage result (wb_*).
- Requester 2: long-latency unit result (lu_*, e.g. mul/div), buffered in a small FIFO.
- Write-back has priority. Buffered results drain in idle slots; a starvation counter forces a one-cycle write-back stall so a drain cannot be postponed indefinitely.
- Sits between the write-back stage and the register file, and exports a pending-rd mask to hazard detection.

Parameters:
- XLEN, 32, data width.
- DEPTH, 2, long-latency result FIFO entries (power of 2, ≥2).
- STARVE_MAX, 4, cycles the FIFO head may wait before a forced drain.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_valid  in  1  write-back stage requests a register write (its reg_write).
- wb_rd  in  5  write-back destination register.
- wb_data  in  XLEN  write-back data.
- lu_valid  in  1  long-latency unit presents a result.
- lu_rd  in  5  long-latency destination register.
- lu_data  in  XLEN  long-latency result.
- lu_ready  out  1  FIFO can accept; push occurs when lu_valid && lu_ready.
- stall_wb  out  1  write-back input ignored this cycle; pipeline must hold it.
- rf_we  out  1  registered register-file write enable.
- rf_rd  out  5  registered write address.
- rf_wdata  out  XLEN  registered write data.
- pend_mask  out  32  bit r set while any FIFO entry targets rd r.
- fifo_count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
Reset:
- All outputs 0 except lu_ready=1.
- FIFO empty, FSM IDLE, starvation counter 0.
- Asserting rst_n low mid-operation discards buffered results.

Write port:
- Registered, 1-cycle latency: a selection in cycle N appears on rf_* in cycle N+1.
- rf_we=0 in any cycle with no selection; rf_rd/rf_wdata then hold their previous values.

x0 handling:
- wb_rd==0 or lu_rd==0 writes are discarded: never selected, never stored.
- An lu push with lu_rd==0 completes (handshake accepted) without entering the FIFO.

Selection, priority order each cycle:
1. state DRAIN: FIFO head is selected and popped; wb_* ignored.
2. wb_valid && wb_rd!=0 && !stall_wb: write-back is selected.
3. FIFO non-empty: FIFO head is selected and popped (free slot).
4. Otherwise: no write.

FIFO:
- lu_ready = (fifo_count < DEPTH), a combinational function of count only.
- No push-while-full even if a pop occurs in the same cycle.
- Simultaneous push and pop are allowed when not full; count is unchanged.
- Pointers wrap modulo DEPTH.
- Push and pop in the same cycle on an empty FIFO are not a bypass: the new entry is written no earlier than the next cycle.

pend_mask:
- OR of a one-hot decode of valid entries' rd, computed combinationally from FIFO state.
- Hazard detection must not let a younger instruction write an rd whose pend_mask bit is set. This keeps the two sources ordered per register; the arbiter does not check it.

FSM (stall_wb = state==DRAIN):
- IDLE: FIFO empty; starvation counter held at 0. Goes to PEND when the FIFO becomes non-empty after an update.
- PEND: counter increments each cycle the head is not popped and resets to 0 on any pop.
  - Counter reaching STARVE_MAX-1 while not popped → DRAIN.
  - FIFO becoming empty → IDLE.
- DRAIN: exactly one cycle; pops the head; counter resets.
  - Next state is PEND if entries remain, else IDLE.

Simultaneous events:
- wb_valid during DRAIN: the write-back result is not written; the pipeline re-presents it next cycle because stall_wb was high.
- lu push in the same cycle as a DRAIN pop is allowed if not full before the cycle.

Decomposition:
- Shared package: XLEN, REG_ADDR_W=5, the FSM state enum (IDLE/PEND/DRAIN), and a src_sel enum (NONE/WB/LU) for debug and coverage.
- One natural sub-module: rf_result_fifo (DEPTH x {rd, data}, push/pop, count, per-entry valid for pend_mask).

Test Plan:
1. Reset check: rst_n=0 → rf_we=0, lu_ready=1, pend_mask=0, fifo_count=0. Release reset, then wb_valid, wb_rd=5, wb_data=0xDEADBEEF → next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF.
2. Free-slot drain: push lu rd=7 data=0x11 with wb idle → pend_mask=0x80, fifo_count=1. Next cycle it is popped → following cycle rf_we=1, rf_rd=7, rf_wdata=0x11, pend_mask=0.
3. Starvation: push lu rd=9 data=0x22, then hold wb_valid continuously (rd=3..). With STARVE_MAX=4, stall_wb rises 4 cycles after the push. One cycle later rf_rd=9, rf_wdata=0x22, and the held wb result is written the cycle after.
4. Full FIFO: push two lu results (rd=10, rd=11) under continuous wb traffic → lu_ready=0, fifo_count=2. A further lu_valid is not accepted until a pop. Drain order is 10 then 11.
5. x0: wb_rd=0 and lu_rd=0 requests → rf_we stays 0, fifo_count stays 0, and the lu handshake still completes (lu_ready=1).
6. Async reset mid-PEND: one entry buffered, rst_n pulsed low between clock edges → immediately fifo_count=0, stall_wb=0, rf_we=0, pend_mask=0.
